// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: signed W x W -> 2W product, one Booth step per clock.
// Optional macro BOOTH_ZERO_SKIP_EN: zero operands bypass RUN and finish in one cycle.
module booth_mult_seq #(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [W-1:0]   mcand,
    input  logic signed [W-1:0]   mplier,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic signed [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [W:0]   a;
    logic signed [W:0]   m;
    logic signed [W:0]   a_sum;
    logic signed [W:0]   a_sh;
    logic        [W-1:0] q;
    logic        [W-1:0] q_sh;
    logic                q_1;
    logic                q1_sh;
    logic        [CW-1:0] cnt;
    logic                last_step;
    logic                zero_op;

    // Single (W+1)-bit adder: y is inverted and carry injected when subtracting; carry-out dropped.
    function automatic logic signed [W:0] addsub(input logic signed [W:0] x,
                                                 input logic signed [W:0] y,
                                                 input logic              sub);
        addsub = x + (y ^ {(W+1){sub}}) + {{W{1'b0}}, sub};
    endfunction

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_op = (mcand == '0) || (mplier == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign last_step = (cnt == CW'(1));

    always_comb begin
        a_sum = a;
        case ({q[0], q_1})
            2'b01:   a_sum = addsub(a, m, 1'b0);
            2'b10:   a_sum = addsub(a, m, 1'b1);
            default: a_sum = a;
        endcase
        // Arithmetic shift of {A,Q,q_1}; A's sign bit is replicated.
        a_sh  = {a_sum[W], a_sum[W:1]};
        q_sh  = {a_sum[0], q[W-1:1]};
        q1_sh = q[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_op ? DONE : RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= '0;
            m       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a   <= '0;
                        q   <= mplier;
                        q_1 <= 1'b0;
                        m   <= {mcand[W-1], mcand};
                        cnt <= CW'(W);
                        if (zero_op) product <= '0;
                    end
                end
                RUN: begin
                    a   <= a_sh;
                    q   <= q_sh;
                    q_1 <= q1_sh;
                    cnt <= cnt - CW'(1);
                    if (last_step) product <= {a_sh[W-1:0], q_sh};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq at W=8 and W=16.
module tb_booth_mult_seq;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start8 = 1'b0;
    logic signed [7:0]  mcand8 = '0;
    logic signed [7:0]  mplier8 = '0;
    logic               ready8, busy8, done8;
    logic signed [15:0] product8;
    logic               start16 = 1'b0;
    logic signed [15:0] mcand16 = '0;
    logic signed [15:0] mplier16 = '0;
    logic               ready16, busy16, done16;
    logic signed [31:0] product16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mcand(mcand8), .mplier(mplier8),
        .ready(ready8), .busy(busy8), .done(done8), .product(product8)
    );

    booth_mult_seq #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .mcand(mcand16), .mplier(mplier16),
        .ready(ready16), .busy(busy16), .done(done16), .product(product16)
    );

    // lat = edges after the accepting edge at which done is first seen; -1 on timeout
    task automatic run8(input logic signed [7:0] mc, input logic signed [7:0] mp,
                        output logic [15:0] prod, output int lat, output int busy_n,
                        output int overlap, output logic rdy_after);
        @(negedge clk);
        start8 = 1'b1; mcand8 = mc; mplier8 = mp;
        @(posedge clk); #1;
        start8 = 1'b0; mcand8 = 8'sh5A; mplier8 = 8'shA5;
        lat = -1; busy_n = 0; overlap = 0;
        for (int i = 0; i <= 40; i++) begin
            if (busy8 && done8) overlap++;
            if (done8) begin
                lat = i;
                break;
            end
            if (busy8) busy_n++;
            @(posedge clk); #1;
        end
        prod = product8;
        @(posedge clk); #1;
        rdy_after = ready8 && !done8;
    endtask

    task automatic run16(input logic signed [15:0] mc, input logic signed [15:0] mp,
                         output logic [31:0] prod, output int lat);
        @(negedge clk);
        start16 = 1'b1; mcand16 = mc; mplier16 = mp;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = -1;
        for (int i = 0; i <= 60; i++) begin
            if (done16) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        prod = product16;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl8 got r/b/d=%b%b%b exp 100", ready8, busy8, done8);
        end
        checks++;
        if (product8 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_product8 got %h exp 0000", product8);
        end
        checks++;
        if (ready16 !== 1'b1 || busy16 !== 1'b0 || done16 !== 1'b0 || product16 !== 32'h0) begin
            errors++;
            $display("FAIL reset_w16 got r/b/d=%b%b%b p=%h exp 100 p=0", ready16, busy16, done16, product16);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] p; int lat, bn, ov; logic rdy;
        run8(8'sd7, 8'sd3, p, lat, bn, ov, rdy);
        checks++;
        if (p !== 16'h0015) begin errors++; $display("FAIL basic_product got %h exp 0015", p); end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_done_latency got %0d exp 8", lat); end
        checks++;
        if (bn !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 8", bn); end
        checks++;
        if (ov !== 0) begin errors++; $display("FAIL basic_busy_done_overlap got %0d exp 0", ov); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL basic_ready_return got %b exp 1", rdy); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (product8 !== 16'h0015) begin errors++; $display("FAIL basic_product_hold got %h exp 0015", product8); end
    endtask

    task automatic test_signed();
        logic signed [7:0] mc_t [3] = '{-8'sd128, -8'sd128, -8'sd1};
        logic signed [7:0] mp_t [3] = '{-8'sd128,  8'sd127, -8'sd1};
        logic [15:0]       ex_t [3] = '{16'h4000, 16'hC080, 16'h0001};
        logic [15:0] p; int lat, bn, ov; logic rdy;
        for (int k = 0; k < 3; k++) begin
            run8(mc_t[k], mp_t[k], p, lat, bn, ov, rdy);
            checks++;
            if (p !== ex_t[k] || lat !== 8) begin
                errors++;
                $display("FAIL signed_%0d got p=%h lat=%0d exp p=%h lat=8", k, p, lat, ex_t[k]);
            end
        end
    endtask

    task automatic test_zero();
        logic [15:0] p; int lat, bn, ov; logic rdy;
        int exp_lat, exp_busy;
`ifdef BOOTH_ZERO_SKIP_EN
        exp_lat = 0; exp_busy = 0;
`else
        exp_lat = 8; exp_busy = 8;
`endif
        run8(8'sd0, 8'sh55, p, lat, bn, ov, rdy);
        checks++;
        if (p !== 16'h0000) begin errors++; $display("FAIL zero_product got %h exp 0000", p); end
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL zero_latency got %0d exp %0d", lat, exp_lat); end
        checks++;
        if (bn !== exp_busy) begin errors++; $display("FAIL zero_busy got %0d exp %0d", bn, exp_busy); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL zero_ready got %b exp 1", rdy); end
    endtask

    task automatic test_ignore_start();
        int pulses = 0; int lat = -1; int ov = 0;
        logic [15:0] p = '0;
        @(negedge clk);
        start8 = 1'b1; mcand8 = 8'sd2; mplier8 = 8'sd3;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 3) begin
                @(negedge clk);
                start8 = 1'b1; mcand8 = 8'sd5; mplier8 = 8'sd5;
            end
            @(posedge clk); #1;
            start8 = 1'b0;
            if (busy8 && done8) ov++;
            if (done8) begin
                pulses++;
                if (pulses == 1) begin
                    p = product8;
                    lat = i;
                end
            end
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL ignore_done_pulses got %0d exp 1", pulses); end
        checks++;
        if (p !== 16'h0006 || lat !== 8) begin
            errors++;
            $display("FAIL ignore_result got p=%h lat=%0d exp p=0006 lat=8", p, lat);
        end
        checks++;
        if (ov !== 0) begin errors++; $display("FAIL ignore_overlap got %0d exp 0", ov); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p; int lat, bn, ov; logic rdy;
        run8(8'sd2, 8'sd3, p, lat, bn, ov, rdy);
        checks++;
        if (p !== 16'h0006 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got p=%h rdy=%b exp p=0006 rdy=1", p, rdy);
        end
        run8(8'sd5, 8'sd5, p, lat, bn, ov, rdy);
        checks++;
        if (p !== 16'h0019 || lat !== 8) begin
            errors++;
            $display("FAIL b2b_second got p=%h lat=%0d exp p=0019 lat=8", p, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p; int lat, bn, ov; logic rdy;
        @(negedge clk);
        start8 = 1'b1; mcand8 = 8'sd100; mplier8 = 8'sd100;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (busy8 !== 1'b1) begin errors++; $display("FAIL rstmid_running got busy=%b exp 1", busy8); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (product8 !== 16'h0000) begin errors++; $display("FAIL rstmid_product got %h exp 0000", product8); end
        checks++;
        if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl got r/b/d=%b%b%b exp 100", ready8, busy8, done8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run8(-8'sd3, 8'sd9, p, lat, bn, ov, rdy);
        checks++;
        if (p !== 16'hFFE5 || lat !== 8) begin
            errors++;
            $display("FAIL rstmid_after got p=%h lat=%0d exp p=ffe5 lat=8", p, lat);
        end
    endtask

    task automatic test_w16();
        logic [31:0] p; int lat;
        run16(-16'sd32768, -16'sd1, p, lat);
        checks++;
        if (p !== 32'h0000_8000 || lat !== 16) begin
            errors++;
            $display("FAIL w16_minneg got p=%h lat=%0d exp p=00008000 lat=16", p, lat);
        end
        run16(16'sd32767, 16'sd32767, p, lat);
        checks++;
        if (p !== 32'h3FFF_0001 || lat !== 16) begin
            errors++;
            $display("FAIL w16_maxpos got p=%h lat=%0d exp p=3fff0001 lat=16", p, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_w16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
